mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// Shares the single data-memory port between instruction fetch (IFU) and load/store (LSU).
// Accepts one request at a time, registers it and drives it to memory, then routes the response back to the owner.
// Fixed LSU-over-IFU priority, with a starvation counter that forces an IFU grant.
// Sits between IFU/LSU and the memory model / bus bridge. One transaction outstanding at most.
// PARAMETERS
// AW           32  address width
// DW           32  data width
// STARVE_LIMIT 4   consecutive contested LSU grants before IFU is forced to win (>=1)
// PORTS
// clk            in   1   clock, rising edge
// rst            in   1   asynchronous, active-low reset (0 = reset)
// ifu_req_valid  in   1   IFU read request
// ifu_req_ready  out  1   IFU request accepted this cycle
// ifu_addr       in   AW  IFU fetch address
// ifu_rsp_valid  out  1   IFU response valid
// ifu_rsp_ready  in   1   IFU can take response
// ifu_rdata      out  DW  IFU read data
// ifu_rsp_err    out  1   IFU access fault
// lsu_req_valid  in   1   LSU request
// lsu_req_ready  out  1   LSU request accepted this cycle
// lsu_addr       in   AW  LSU address
// lsu_wen        in   1   1 = store, 0 = load
// lsu_size       in   2   0=byte 1=half 2=word
// lsu_wdata      in   DW  store data
// lsu_rsp_valid  out  1   LSU response valid (load data or store ack)
// lsu_rsp_ready  in   1   LSU can take response
// lsu_rdata      out  DW  load data, raw (LSU extends)
// lsu_rsp_err    out  1   LSU access fault
// mem_req_valid  out  1   request to memory
// mem_req_ready  in   1   memory accepts request
// mem_addr/mem_wen/mem_size/mem_wdata  out  AW/1/2/DW  registered request payload
// mem_rsp_valid  in   1   memory response
// mem_rsp_ready  out  1   arbiter takes response
// mem_rdata/mem_rsp_err  in  DW/1  response payload
// BEHAVIOUR
// Reset: state=S_IDLE, owner=IFU, starve_cnt=0. All valid/ready outputs 0. mem_addr/wen/size/wdata = 0.
// FSM: S_IDLE -> S_REQ -> S_RSP -> S_IDLE.
// S_IDLE arbitration:
// - winner = LSU if lsu_req_valid and not (ifu_req_valid and starve_cnt==STARVE_LIMIT); else IFU if ifu_req_valid.
// - Winner's *_req_ready=1 combinationally, only in S_IDLE; loser's ready=0.
// - On a grant: latch payload into mem_* regs, set owner, go S_REQ.
// - IFU grant latches wen=0, size=2, wdata=0.
// starve_cnt:
// - +1 on an LSU grant while ifu_req_valid=1 (saturates at STARVE_LIMIT).
// - Cleared on an IFU grant, or on an LSU grant with ifu_req_valid=0. Otherwise held.
// S_REQ: mem_req_valid=1 with a stable payload. Go S_RSP when mem_req_ready=1.
// S_RSP routing:
// - owner_rsp_valid = mem_rsp_valid. Owner's rdata/err = mem_rdata/mem_rsp_err (combinational).
// - Non-owner rsp_valid=0, rdata=0, err=0.
// - mem_rsp_ready = owner's rsp_ready.
// - Go S_IDLE on mem_rsp_valid & owner_rsp_ready.
// Min latency: grant at cycle 0, mem_req_valid at cycle 1.
// - With mem_req_ready=1 at cycle 1 and mem_rsp_valid=1 at cycle 2, response is handed over at cycle 2.
// - Next grant no earlier than cycle 3.
// mem_rsp_valid outside S_RSP: ignored (mem_rsp_ready=0, no *_rsp_valid).
// Both *_rsp_valid are never 1 in the same cycle. Neither *_req_ready is 1 outside S_IDLE.
// Reset asserted mid-transaction: immediate return to reset state, pending request/response dropped (memory is reset with the core).
// TESTING
// 1 Reset mid S_RSP -> all valid/ready outputs 0 in the same cycle; after release, state S_IDLE, starve_cnt=0.
// 2 IFU only: addr 0x8000_0000, mem ready same cycle, rdata 0x0000_0413 at cycle 2 -> ifu_req_ready at 0, mem_req_valid at 1, ifu_rsp_valid+rdata at 2; lsu_rsp_valid stays 0.
// 3 Both valid at cycle 0: LSU store 0x8000_1000 data 0xDEADBEEF size 2 -> LSU granted; mem_wen=1 and mem_wdata=0xDEADBEEF held while mem_req_ready=0 for 3 cycles.
// 4 LSU and IFU valid continuously, STARVE_LIMIT=4 -> grants LSU,LSU,LSU,LSU,IFU,LSU... ; starve_cnt sequence 1,2,3,4,0.
// 5 LSU load, lsu_rsp_ready=0 for 2 cycles after mem_rsp_valid -> mem_rsp_ready=0 and state held; transfer completes on the first cycle lsu_rsp_ready=1.
// 6 mem_rsp_valid pulsed in S_IDLE, then mem_rsp_err=1 on an IFU read -> stray pulse ignored; ifu_rsp_err=1 and lsu_rsp_err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// LSU wins by default; a starvation counter forces an IFU grant after STARVE_LIMIT contested LSU wins.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_rsp_valid,
    input  logic          ifu_rsp_ready,
    output logic [DW-1:0] ifu_rdata,
    output logic          ifu_rsp_err,
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic          lsu_wen,
    input  logic [1:0]    lsu_size,
    input  logic [DW-1:0] lsu_wdata,
    output logic          lsu_rsp_valid,
    input  logic          lsu_rsp_ready,
    output logic [DW-1:0] lsu_rdata,
    output logic          lsu_rsp_err,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [1:0]    mem_size,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_rsp_valid,
    output logic          mem_rsp_ready,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rsp_err
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

    state_t          state, state_nxt;
    logic            owner_lsu;
    logic [CW-1:0]   starve_cnt;
    logic            starve_hit;
    logic            lsu_win;
    logic            ifu_win;
    logic            grant;
    logic            owner_rsp_ready;

    always_comb begin
        state_nxt       = state;
        starve_hit      = ifu_req_valid && (starve_cnt == CW'(STARVE_LIMIT));
        lsu_win         = lsu_req_valid && !starve_hit;
        ifu_win         = ifu_req_valid && !lsu_win;
        grant           = 1'b0;
        owner_rsp_ready = owner_lsu ? lsu_rsp_ready : ifu_rsp_ready;
        ifu_req_ready   = 1'b0;
        lsu_req_ready   = 1'b0;
        mem_req_valid   = 1'b0;
        mem_rsp_ready   = 1'b0;
        ifu_rsp_valid   = 1'b0;
        ifu_rdata       = '0;
        ifu_rsp_err     = 1'b0;
        lsu_rsp_valid   = 1'b0;
        lsu_rdata       = '0;
        lsu_rsp_err     = 1'b0;
        case (state)
            S_IDLE: begin
                // readies are masked by reset so nothing looks accepted while held in reset
                ifu_req_ready = ifu_win & rst;
                lsu_req_ready = lsu_win & rst;
                grant         = lsu_win | ifu_win;
                if (grant) state_nxt = S_REQ;
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nxt = S_RSP;
            end
            S_RSP: begin
                mem_rsp_ready = owner_rsp_ready;
                if (owner_lsu) begin
                    lsu_rsp_valid = mem_rsp_valid;
                    lsu_rdata     = mem_rdata;
                    lsu_rsp_err   = mem_rsp_err;
                end else begin
                    ifu_rsp_valid = mem_rsp_valid;
                    ifu_rdata     = mem_rdata;
                    ifu_rsp_err   = mem_rsp_err;
                end
                if (mem_rsp_valid && owner_rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            owner_lsu  <= 1'b0;
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_size   <= 2'd0;
            mem_wdata  <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner_lsu <= lsu_win;
                mem_addr  <= lsu_win ? lsu_addr : ifu_addr;
                mem_wen   <= lsu_win & lsu_wen;
                mem_size  <= lsu_win ? lsu_size : 2'd2;
                mem_wdata <= lsu_win ? lsu_wdata : '0;
                // only an LSU win over a waiting IFU counts toward starvation
                if (lsu_win && ifu_req_valid) begin
                    if (starve_cnt != CW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + CW'(1);
                end else begin
                    starve_cnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard queue holds the expected response of each granted
// request and a negedge monitor pops and compares it when the owner takes the response.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
    logic [AW-1:0] lsu_addr;
    logic [1:0]    lsu_size;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_size;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
        .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_size(lsu_size), .lsu_wdata(lsu_wdata),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
        .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_size(mem_size), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
        .mem_rsp_err(mem_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_lsu;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_cnt    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && (ifu_rsp_valid || lsu_rsp_valid)) begin
            chk("rsp_exclusive", ifu_rsp_valid & lsu_rsp_valid, 1'b0);
            if ((ifu_rsp_valid && ifu_rsp_ready) || (lsu_rsp_valid && lsu_rsp_ready)) begin
                chk("sb_nonempty", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rsp_owner", lsu_rsp_valid, e.is_lsu);
                    chk("rsp_data", lsu_rsp_valid ? lsu_rdata : ifu_rdata, e.data);
                    chk("rsp_err", lsu_rsp_valid ? lsu_rsp_err : ifu_rsp_err, e.err);
                end
            end
        end
    end

    // one full transaction starting from S_IDLE at posedge+1; ends at posedge+1 back in S_IDLE
    task automatic txn(input logic iv, input logic lv, input logic [AW-1:0] iaddr,
                       input logic [AW-1:0] laddr, input logic wen, input logic [1:0] size,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] rdata, input logic err,
                       input int req_wait, input int rsp_wait);
        logic          win_lsu;
        logic [AW-1:0] ea;
        logic          ewen;
        logic [1:0]    esz;
        logic [DW-1:0] ewd;
        ifu_req_valid = iv;  ifu_addr = iaddr;
        lsu_req_valid = lv;  lsu_addr = laddr; lsu_wen = wen; lsu_size = size; lsu_wdata = wdata;
        win_lsu = lv && !(iv && m_cnt == LIMIT);
        ea   = win_lsu ? laddr : iaddr;
        ewen = win_lsu ? wen : 1'b0;
        esz  = win_lsu ? size : 2'd2;
        ewd  = win_lsu ? wdata : '0;
        if (win_lsu && iv) m_cnt = (m_cnt == LIMIT) ? LIMIT : m_cnt + 1;
        else               m_cnt = 0;
        sb_q.push_back('{win_lsu, rdata, err});
        #1;
        chk("lsu_req_ready", lsu_req_ready, win_lsu);
        chk("ifu_req_ready", ifu_req_ready, !win_lsu);
        chk("mem_req_valid_c0", mem_req_valid, 1'b0);
        cyc();
        mem_req_ready = (req_wait == 0);
        #1;
        chk("starve_cnt", dut.starve_cnt, m_cnt);
        chk("req_ready_busy", ifu_req_ready | lsu_req_ready, 1'b0);
        for (int i = 0; i <= req_wait; i++) begin
            if (i > 0) begin
                cyc();
                mem_req_ready = (i == req_wait);
                #1;
            end
            chk("mem_req_valid", mem_req_valid, 1'b1);
            chk("mem_addr", mem_addr, ea);
            chk("mem_wen", mem_wen, ewen);
            chk("mem_size", mem_size, esz);
            chk("mem_wdata", mem_wdata, ewd);
        end
        cyc();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = rdata; mem_rsp_err = err;
        for (int i = 0; i <= rsp_wait; i++) begin
            if (i > 0) cyc();
            if (win_lsu) lsu_rsp_ready = (i == rsp_wait);
            else         ifu_rsp_ready = (i == rsp_wait);
            #1;
            chk("mem_req_valid_rsp", mem_req_valid, 1'b0);
            chk("mem_rsp_ready", mem_rsp_ready, i == rsp_wait);
            chk("owner_rsp_valid", win_lsu ? lsu_rsp_valid : ifu_rsp_valid, 1'b1);
            chk("other_rsp_valid", win_lsu ? ifu_rsp_valid : lsu_rsp_valid, 1'b0);
            chk("other_rdata", win_lsu ? ifu_rdata : lsu_rdata, '0);
            chk("other_err", win_lsu ? ifu_rsp_err : lsu_rsp_err, 1'b0);
        end
        cyc();
        mem_rsp_valid = 1'b0; mem_rdata = '0; mem_rsp_err = 1'b0;
        ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = '0; ifu_rsp_ready = 1'b1;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_size = 2'd0; lsu_wdata = '0;
        lsu_rsp_ready = 1'b1;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; mem_rsp_err = 1'b0;
        cyc(); cyc();
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_mem_wen_size", {mem_wen, mem_size}, 3'b000);
        chk("rst_starve_cnt", dut.starve_cnt, 0);
        rst = 1'b1;
        cyc();

        // IFU-only fetch, minimum latency
        txn(1'b1, 1'b0, 32'h8000_0000, '0, 1'b0, 2'd0, '0, 32'h0000_0413, 1'b0, 0, 0);
        // contested store held while memory stalls
        txn(1'b1, 1'b1, 32'h8000_0040, 32'h8000_1000, 1'b1, 2'd2, 32'hDEAD_BEEF, '0, 1'b0, 3, 0);
        // LSU load with response back-pressure
        txn(1'b0, 1'b1, '0, 32'h8000_2004, 1'b0, 2'd1, '0, 32'h1234_5678, 1'b0, 1, 2);
        // both requesters continuously: LSU x4 then forced IFU then LSU
        for (int i = 0; i < 6; i++)
            txn(1'b1, 1'b1, 32'h8000_0100 + 32'(i * 4), 32'h8000_3000 + 32'(i * 4), 1'b0, 2'd0, '0,
                32'h0000_A000 + 32'(i), 1'b0, 0, 0);

        // stray memory response while idle, then a faulting IFU read
        mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF; mem_rsp_err = 1'b1;
        #1;
        chk("stray_mem_rsp_ready", mem_rsp_ready, 1'b0);
        chk("stray_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        cyc();
        mem_rsp_valid = 1'b0; mem_rdata = '0; mem_rsp_err = 1'b0;
        #1;
        chk("stray_idle_mem_req", mem_req_valid, 1'b0);
        cyc();
        txn(1'b1, 1'b0, 32'hF000_0000, '0, 1'b0, 2'd0, '0, 32'h0000_0BAD, 1'b1, 0, 0);

        // reset asserted while an LSU response is pending
        lsu_req_valid = 1'b1; ifu_req_valid = 1'b1; lsu_addr = 32'h8000_4000; lsu_wen = 1'b0;
        #1;
        chk("mid_lsu_grant", lsu_req_ready, 1'b1);
        cyc();
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_AAAA; lsu_rsp_ready = 1'b0;
        #1;
        chk("mid_lsu_rsp_valid", lsu_rsp_valid, 1'b1);
        chk("mid_starve_cnt", dut.starve_cnt, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valids", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 3'b000);
        chk("mid_rst_readies", {ifu_req_ready, lsu_req_ready, mem_rsp_ready}, 3'b000);
        chk("mid_rst_mem_addr", mem_addr, '0);
        cyc();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        lsu_rsp_ready = 1'b1;
        rst = 1'b1;
        m_cnt = 0;
        #1;
        chk("post_rst_state", int'(dut.state), 0);
        chk("post_rst_starve_cnt", dut.starve_cnt, 0);
        cyc();
        txn(1'b1, 1'b0, 32'h8000_0080, '0, 1'b0, 2'd0, '0, 32'h0000_0013, 1'b0, 0, 0);

        cyc();
        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
